// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
//   Shared definitions for the ALU BIST response-compaction stage.
//   - state_e      : run-control FSM states (IDLE, RUN, DONE), 2-bit encoded
//   - MISR_W       : width of the signature register the polynomial is defined for
//   - MISR_TAPS    : feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   - DEFAULT_SEED : signature value loaded at the start of every run
//   - misr_next()  : one MISR step, shared by the MISR register and the
//                    verdict logic so both see the same next-state signature
// -----------------------------------------------------------------------------
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int             MISR_W       = 8;
    localparam logic [MISR_W-1:0] MISR_TAPS = 8'b1011_1000;
    localparam logic [MISR_W-1:0] DEFAULT_SEED = 8'h00;

    // Shift left, feed the XOR of the tapped bits into bit 0, then fold in
    // the incoming response word.
    function automatic logic [MISR_W-1:0] misr_next(
        input logic [MISR_W-1:0] sig,
        input logic [MISR_W-1:0] din
    );
        logic fb;
        fb = ^(sig & MISR_TAPS);
        return {sig[MISR_W-2:0], fb} ^ din;
    endfunction

endpackage : bist_pkg

// File: rtl/bist_misr.sv
// -----------------------------------------------------------------------------
// bist_misr
//   Multiple-input signature register. Holds the compacted ALU response.
//   Ports:
//     clk   in  1   rising-edge clock
//     rst   in  1   synchronous active-high reset, signature returns to seed
//     load  in  1   reload the signature with seed (start of a run)
//     en    in  1   fold din into the signature this cycle
//     seed  in  DW  value loaded on reset and on load
//     din   in  DW  response word to compact
//     sig   out DW  current signature
//   load has priority over en.
// -----------------------------------------------------------------------------
module bist_misr
    import bist_pkg::*;
#(
    parameter int DW = MISR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [DW-1:0] seed,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] sig
);

    logic [DW-1:0] sig_q;
    logic [DW-1:0] sig_d;

    // NOTE: every variable written in an always_comb gets a default on entry
    // so that no path leaves it unassigned and infers a latch.
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (en) begin
            sig_d = misr_next(sig_q, din);
        end
    end

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its sources, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= seed;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule : bist_misr

// File: rtl/bist_signature_analyzer.sv
// -----------------------------------------------------------------------------
// bist_signature_analyzer
//   Response-compaction stage of the ALU BIST loop. For each accepted pattern
//   it folds the ALU result into an 8-bit MISR, compares the ALU result with
//   the reference-model result, counts mismatches (saturating) and captures
//   the index of the first failing pattern. After NUM_PATTERNS accepted
//   patterns it stops and reports a registered pass/fail verdict.
//   Ports:
//     clk             in   1   rising-edge clock
//     rst             in   1   synchronous active-high reset
//     start           in   1   begin a run from IDLE or DONE (ignored in RUN)
//     pat_valid       in   1   alu_result/ref_result valid this cycle
//     alu_result      in   DW  ALU output under test
//     ref_result      in   DW  reference-model output
//     golden_sig      in   DW  expected final signature
//     next_pattern    out  1   request next pattern (same as busy)
//     busy            out  1   run in progress
//     done            out  1   run finished, held until start or rst
//     pass            out  1   verdict, valid while done
//     signature       out  DW  current MISR contents
//     mismatch_count  out  CW  mismatching patterns, saturating at all-ones
//     first_fail_vld  out  1   a mismatch has been seen this run
//     first_fail_idx  out  CW  0-based index of the first mismatch
// -----------------------------------------------------------------------------
module bist_signature_analyzer
    import bist_pkg::*;
#(
    parameter int          DW           = 8,
    parameter int          NUM_PATTERNS = 255,
    parameter int          CW           = 8,
    parameter logic [DW-1:0] MISR_SEED  = DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pat_valid,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] ref_result,
    input  logic [DW-1:0] golden_sig,
    output logic          next_pattern,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [DW-1:0] signature,
    output logic [CW-1:0] mismatch_count,
    output logic          first_fail_vld,
    output logic [CW-1:0] first_fail_idx
);

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PATTERNS - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_e        state_q;
    logic [CW-1:0] idx_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ffv_q;
    logic [CW-1:0] ffi_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic          pass_d;

    logic          accept;
    logic          begin_run;
    logic          mismatch;
    logic [DW-1:0] sig_cur;
    logic [DW-1:0] sig_next;

    assign accept    = (state_q == RUN) && pat_valid;
    assign begin_run = start && (state_q != RUN);
    assign mismatch  = (alu_result != ref_result);

    bist_misr #(
        .DW (DW)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (begin_run),
        .en   (accept),
        .seed (MISR_SEED),
        .din  (alu_result),
        .sig  (sig_cur)
    );

    // Next-state signature and count as they will be after the current
    // acceptance; the verdict is taken from these so that pass is already
    // correct on the first DONE cycle.
    assign sig_next = misr_next(sig_cur, alu_result);

    always_comb begin
        cnt_d = cnt_q;
        if (accept && mismatch && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign pass_d = (sig_next == golden_sig) && (cnt_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ffv_q   <= 1'b0;
            ffi_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        ffv_q   <= 1'b0;
                        ffi_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (pat_valid) begin
                        idx_q <= idx_q + 1'b1;
                        cnt_q <= cnt_d;
                        // Only the first failure is recorded for this run.
                        if (mismatch && !ffv_q) begin
                            ffv_q <= 1'b1;
                            ffi_q <= idx_q;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= pass_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign next_pattern   = busy_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign signature      = sig_cur;
    assign mismatch_count = cnt_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_idx = ffi_q;

endmodule : bist_signature_analyzer

// File: tb/tb_bist_signature_analyzer.sv
// -----------------------------------------------------------------------------
// tb_bist_signature_analyzer
//   Directed bench for bist_signature_analyzer. Three instances:
//     u_dut0 : default parameters (255 patterns)
//     u_dut1 : NUM_PATTERNS=2
//     u_dut2 : CW=2, NUM_PATTERNS=3
//   Inputs change 1 ns after a rising edge; outputs are checked 1 ns after
//   the following rising edge.
// -----------------------------------------------------------------------------
module tb_bist_signature_analyzer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // ---------------- instance 0: defaults ----------------
    logic       s0_start, s0_pv;
    logic [7:0] s0_alu, s0_ref, s0_gold;
    logic       s0_np, s0_busy, s0_done, s0_pass, s0_ffv;
    logic [7:0] s0_sig, s0_cnt, s0_ffi;

    bist_signature_analyzer u_dut0 (
        .clk            (clk),
        .rst            (rst),
        .start          (s0_start),
        .pat_valid      (s0_pv),
        .alu_result     (s0_alu),
        .ref_result     (s0_ref),
        .golden_sig     (s0_gold),
        .next_pattern   (s0_np),
        .busy           (s0_busy),
        .done           (s0_done),
        .pass           (s0_pass),
        .signature      (s0_sig),
        .mismatch_count (s0_cnt),
        .first_fail_vld (s0_ffv),
        .first_fail_idx (s0_ffi)
    );

    // ---------------- instance 1: two patterns ----------------
    logic       s1_start, s1_pv;
    logic [7:0] s1_alu, s1_ref, s1_gold;
    logic       s1_np, s1_busy, s1_done, s1_pass, s1_ffv;
    logic [7:0] s1_sig, s1_cnt, s1_ffi;

    bist_signature_analyzer #(
        .NUM_PATTERNS (2)
    ) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .start          (s1_start),
        .pat_valid      (s1_pv),
        .alu_result     (s1_alu),
        .ref_result     (s1_ref),
        .golden_sig     (s1_gold),
        .next_pattern   (s1_np),
        .busy           (s1_busy),
        .done           (s1_done),
        .pass           (s1_pass),
        .signature      (s1_sig),
        .mismatch_count (s1_cnt),
        .first_fail_vld (s1_ffv),
        .first_fail_idx (s1_ffi)
    );

    // ---------------- instance 2: narrow counter ----------------
    logic       s2_start, s2_pv;
    logic [7:0] s2_alu, s2_ref, s2_gold;
    logic       s2_np, s2_busy, s2_done, s2_pass, s2_ffv;
    logic [7:0] s2_sig;
    logic [1:0] s2_cnt, s2_ffi;

    bist_signature_analyzer #(
        .CW           (2),
        .NUM_PATTERNS (3)
    ) u_dut2 (
        .clk            (clk),
        .rst            (rst),
        .start          (s2_start),
        .pat_valid      (s2_pv),
        .alu_result     (s2_alu),
        .ref_result     (s2_ref),
        .golden_sig     (s2_gold),
        .next_pattern   (s2_np),
        .busy           (s2_busy),
        .done           (s2_done),
        .pass           (s2_pass),
        .signature      (s2_sig),
        .mismatch_count (s2_cnt),
        .first_fail_vld (s2_ffv),
        .first_fail_idx (s2_ffi)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signature reference: x^8+x^6+x^5+x^4+1, feedback from bits 7,5,4,3.
    function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ d;
    endfunction

    function automatic logic [7:0] alu_a(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [7:0] alu_b(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    logic [7:0] exp_sig;
    logic [7:0] run_sig;

    initial begin
        rst = 1'b1;
        s0_start = 0; s0_pv = 0; s0_alu = 0; s0_ref = 0; s0_gold = 0;
        s1_start = 0; s1_pv = 0; s1_alu = 0; s1_ref = 0; s1_gold = 0;
        s2_start = 0; s2_pv = 0; s2_alu = 0; s2_ref = 0; s2_gold = 0;
        tick();
        tick();
        rst = 1'b0;

        // ---- reset state ----
        chk("reset_busy", s0_busy, 0);
        chk("reset_done", s0_done, 0);
        chk("reset_pass", s0_pass, 0);
        chk("reset_sig",  s0_sig,  8'h00);
        chk("reset_cnt",  s0_cnt,  0);
        chk("reset_np",   s0_np,   0);

        // ---- T1: reset in the middle of a run ----
        s0_start = 1; tick(); s0_start = 0;
        chk("t1_busy_after_start", s0_busy, 1);
        chk("t1_np_after_start",   s0_np,   1);
        s0_pv = 1; s0_alu = 8'h11; s0_ref = 8'h22;
        tick(); tick();
        s0_pv = 0;
        chk("t1_cnt_midrun", s0_cnt, 2);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("t1_busy", s0_busy, 0);
        chk("t1_done", s0_done, 0);
        chk("t1_pass", s0_pass, 0);
        chk("t1_np",   s0_np,   0);
        chk("t1_sig",  s0_sig,  8'h00);
        chk("t1_cnt",  s0_cnt,  0);
        chk("t1_ffv",  s0_ffv,  0);
        chk("t1_ffi",  s0_ffi,  0);

        // pat_valid while idle must not disturb anything
        s0_pv = 1; s0_alu = 8'hFF; s0_ref = 8'h00;
        tick();
        s0_pv = 0;
        chk("idle_pv_sig",  s0_sig,  8'h00);
        chk("idle_pv_busy", s0_busy, 0);
        chk("idle_pv_cnt",  s0_cnt,  0);

        // ---- T3: 255 patterns, mismatches at indices 7 and 40 ----
        exp_sig = 8'h00;
        for (int i = 0; i < 255; i++) exp_sig = misr_ref(exp_sig, alu_a(i));
        s0_gold = exp_sig;
        s0_start = 1; tick(); s0_start = 0;
        for (int i = 0; i < 255; i++) begin
            s0_pv  = 1;
            s0_alu = alu_a(i);
            s0_ref = (i == 7 || i == 40) ? (alu_a(i) ^ 8'h80) : alu_a(i);
            if (i == 254) chk("t3_done_before_last", s0_done, 0);
            tick();
            if (i == 6) chk("t3_ffv_before_fail", s0_ffv, 0);
            if (i == 7) begin
                chk("t3_cnt_after_7", s0_cnt, 1);
                chk("t3_ffv_after_7", s0_ffv, 1);
                chk("t3_ffi_after_7", s0_ffi, 7);
            end
            if (i == 40) begin
                chk("t3_cnt_after_40", s0_cnt, 2);
                chk("t3_ffi_after_40", s0_ffi, 7);
            end
        end
        s0_pv = 0;
        chk("t3_done", s0_done, 1);
        chk("t3_busy", s0_busy, 0);
        chk("t3_np",   s0_np,   0);
        chk("t3_cnt",  s0_cnt,  2);
        chk("t3_ffi",  s0_ffi,  7);
        chk("t3_sig",  s0_sig,  exp_sig);
        chk("t3_pass", s0_pass, 0);
        tick();
        chk("t3_done_held", s0_done, 1);
        chk("t3_sig_held",  s0_sig,  exp_sig);

        // ---- T5: start in DONE clears the run ----
        exp_sig = 8'h00;
        for (int i = 0; i < 255; i++) exp_sig = misr_ref(exp_sig, alu_b(i));
        s0_gold = exp_sig;
        s0_start = 1; tick(); s0_start = 0;
        chk("t5_done_cleared", s0_done, 0);
        chk("t5_busy",         s0_busy, 1);
        chk("t5_cnt_cleared",  s0_cnt,  0);
        chk("t5_ffv_cleared",  s0_ffv,  0);
        chk("t5_ffi_cleared",  s0_ffi,  0);
        chk("t5_sig_seeded",   s0_sig,  8'h00);

        // ---- T4: gapped pat_valid, start pulsed mid-run ----
        run_sig = 8'h00;
        for (int i = 0; i < 255; i++) begin
            s0_pv  = 1;
            s0_alu = alu_b(i);
            s0_ref = alu_b(i);
            tick();
            s0_pv = 0;
            run_sig = misr_ref(run_sig, alu_b(i));
            if (i < 3) begin
                chk("t4_sig_on_valid", s0_sig, run_sig);
                if (i == 1) s0_start = 1;
                tick();
                s0_start = 0;
                tick();
                chk("t4_sig_in_gap",  s0_sig,  run_sig);
                chk("t4_busy_in_gap", s0_busy, 1);
            end
            if (i == 253) chk("t4_done_early", s0_done, 0);
        end
        chk("t4_done", s0_done, 1);
        chk("t4_sig",  s0_sig,  exp_sig);
        chk("t4_cnt",  s0_cnt,  0);
        chk("t4_ffv",  s0_ffv,  0);
        chk("t4_pass", s0_pass, 1);

        // ---- T2: two patterns, signature 01 then 02 ----
        s1_gold = 8'h02;
        s1_start = 1; tick(); s1_start = 0;
        chk("t2_busy", s1_busy, 1);
        s1_pv = 1; s1_alu = 8'h01; s1_ref = 8'h01;
        tick();
        chk("t2_sig_first", s1_sig,  8'h01);
        chk("t2_done_mid",  s1_done, 0);
        s1_alu = 8'h00; s1_ref = 8'h00;
        tick();
        s1_pv = 0;
        chk("t2_sig_second", s1_sig,  8'h02);
        chk("t2_done",       s1_done, 1);
        chk("t2_pass_good",  s1_pass, 1);
        chk("t2_ffv",        s1_ffv,  0);

        s1_gold = 8'h03;
        s1_start = 1; tick(); s1_start = 0;
        chk("t2_rerun_sig",  s1_sig,  8'h00);
        chk("t2_rerun_done", s1_done, 0);
        chk("t2_rerun_pass", s1_pass, 0);
        s1_pv = 1; s1_alu = 8'h01; s1_ref = 8'h01;
        tick();
        s1_alu = 8'h00; s1_ref = 8'h00;
        tick();
        s1_pv = 0;
        chk("t2_rerun_sig_final", s1_sig,  8'h02);
        chk("t2_rerun_done_final", s1_done, 1);
        chk("t2_pass_bad_golden", s1_pass, 0);

        // ---- T6: CW=2, three mismatching patterns ----
        s2_start = 1; tick(); s2_start = 0;
        for (int i = 0; i < 3; i++) begin
            s2_pv  = 1;
            s2_alu = 8'(i);
            s2_ref = ~8'(i);
            tick();
            chk("t6_cnt_step", s2_cnt, i + 1);
        end
        s2_pv = 0;
        chk("t6_done", s2_done, 1);
        chk("t6_cnt",  s2_cnt,  2'b11);
        chk("t6_ffv",  s2_ffv,  1);
        chk("t6_ffi",  s2_ffi,  0);
        chk("t6_pass", s2_pass, 0);
        tick();
        chk("t6_cnt_held", s2_cnt, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_bist_signature_analyzer
